// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core run-control sequencer.
package core_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RST_HOLD,
    ST_RUN,
    ST_HALT
  } seq_state_e;

  localparam logic [1:0] HALT_ABORT   = 2'd0;
  localparam logic [1:0] HALT_EBREAK  = 2'd1;
  localparam logic [1:0] HALT_ECALL   = 2'd2;
  localparam logic [1:0] HALT_TIMEOUT = 2'd3;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

  // Returns {hit, cause}; EBREAK is checked before ECALL.
  function automatic logic [2:0] classify_instr(input logic [31:0] instr);
    logic [2:0] res;
    res = 3'b000;
    if (instr == INSTR_EBREAK) begin
      res = {1'b1, HALT_EBREAK};
    end else if (instr == INSTR_ECALL) begin
      res = {1'b1, HALT_ECALL};
    end
    return res;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Program-load handshake: accepts words while active, writes them to
// consecutive instruction memory words and flags the final accepted word.
module imem_loader
  import core_seq_pkg::*;
#(
  parameter int IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic        clear,
  input  logic        abort,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [15:0] load_words,
  output logic        load_done
);

  localparam logic [15:0] LAST_IDX = 16'(IMEM_WORDS - 1);

  logic [15:0] load_words_q;
  logic [15:0] load_words_d;
  logic        accept;

  // An abort in the same cycle as a valid word must not let that word land.
  always_comb begin
    load_ready   = active & ~abort;
    accept       = load_valid & load_ready;
    imem_we      = accept;
    imem_addr    = {14'd0, load_words_q, 2'b00};
    imem_wdata   = load_data;
    load_done    = accept & (load_last | (load_words_q == LAST_IDX));
    load_words_d = load_words_q;
    if (clear) begin
      load_words_d = '0;
    end else if (accept) begin
      load_words_d = load_words_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_words_q <= '0;
    end else begin
      load_words_q <= load_words_d;
    end
  end

  assign load_words = load_words_q;

endmodule

// File: rtl/core_run_sequencer.sv
// Run-control sequencer: loads a program, holds the core in reset, runs it
// and halts on EBREAK/ECALL/timeout/abort, reporting cause, pc and cycles.
module core_run_sequencer
  import core_seq_pkg::*;
#(
  parameter int IMEM_WORDS   = 1024,
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 100000,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             skip_load,
  input  logic             abort,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [31:0]      load_data,
  input  logic             load_last,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_rst,
  input  logic [31:0]      core_pc,
  input  logic [31:0]      core_instr,
  output logic             busy,
  output logic             done,
  output logic [1:0]       halt_cause,
  output logic [31:0]      halt_pc,
  output logic [CNT_W-1:0] cycle_count,
  output logic [15:0]      load_words
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(MAX_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [1:0]        halt_cause_q, halt_cause_d;
  logic [31:0]       halt_pc_q, halt_pc_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              start_load;
  logic              load_done;
  logic [2:0]        instr_class;

  imem_loader #(
    .IMEM_WORDS(IMEM_WORDS)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .active     (state_q == ST_LOAD),
    .clear      (start_load),
    .abort      (abort),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .load_words (load_words),
    .load_done  (load_done)
  );

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    cycle_count_d = cycle_count_q;
    halt_cause_d  = halt_cause_q;
    halt_pc_d     = halt_pc_q;
    start_load    = 1'b0;
    instr_class   = classify_instr(core_instr);

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          cycle_count_d = '0;
          if (skip_load) begin
            state_d    = ST_RST_HOLD;
            hold_cnt_d = HOLD_INIT;
          end else begin
            state_d    = ST_LOAD;
            start_load = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d      = ST_HALT;
          halt_cause_d = HALT_ABORT;
          halt_pc_d    = '0;
        end else if (load_done) begin
          state_d    = ST_RST_HOLD;
          hold_cnt_d = HOLD_INIT;
        end
      end
      ST_RST_HOLD: begin
        if (abort) begin
          state_d      = ST_HALT;
          halt_cause_d = HALT_ABORT;
          halt_pc_d    = '0;
        end else if (hold_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        // The halting cycle is itself a RUN cycle, so it is counted.
        cycle_count_d = cycle_count_q + 1'b1;
        if (abort) begin
          state_d      = ST_HALT;
          halt_cause_d = HALT_ABORT;
          halt_pc_d    = core_pc;
        end else if (instr_class[2]) begin
          state_d      = ST_HALT;
          halt_cause_d = instr_class[1:0];
          halt_pc_d    = core_pc;
        end else if (cycle_count_q == CNT_LIMIT) begin
          state_d      = ST_HALT;
          halt_cause_d = HALT_TIMEOUT;
          halt_pc_d    = core_pc;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    core_rst_d = (state_d != ST_RUN);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_RST_HOLD) || (state_d == ST_RUN);
    done_d     = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
      halt_cause_q  <= HALT_ABORT;
      halt_pc_q     <= '0;
      core_rst_q    <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      cycle_count_q <= cycle_count_d;
      halt_cause_q  <= halt_cause_d;
      halt_pc_q     <= halt_pc_d;
      core_rst_q    <= core_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign core_rst    = core_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign halt_cause  = halt_cause_q;
  assign halt_pc     = halt_pc_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_core_run_sequencer.sv
// Directed bench for core_run_sequencer with a tiny behavioural core and
// instruction memory (IMEM_WORDS=4, RESET_CYCLES=4, MAX_CYCLES=10).
module tb_core_run_sequencer;
  import core_seq_pkg::*;

  localparam int IMEM_WORDS   = 4;
  localparam int RESET_CYCLES = 4;
  localparam int MAX_CYCLES   = 10;
  localparam int CNT_W        = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             skip_load = 1'b0;
  logic             abort = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [31:0]      load_data = '0;
  logic             load_last = 1'b0;
  logic             imem_we;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic             core_rst;
  logic [31:0]      core_pc = '0;
  logic [31:0]      core_instr;
  logic             busy;
  logic             done;
  logic [1:0]       halt_cause;
  logic [31:0]      halt_pc;
  logic [CNT_W-1:0] cycle_count;
  logic [15:0]      load_words;

  logic [31:0] mem [16] = '{default: 32'h0000_0013};
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  int compared = 0;
  int mismatched = 0;
  int n;

  core_run_sequencer #(
    .IMEM_WORDS  (IMEM_WORDS),
    .RESET_CYCLES(RESET_CYCLES),
    .MAX_CYCLES  (MAX_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .skip_load  (skip_load),
    .abort      (abort),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .core_pc    (core_pc),
    .core_instr (core_instr),
    .busy       (busy),
    .done       (done),
    .halt_cause (halt_cause),
    .halt_pc    (halt_pc),
    .cycle_count(cycle_count),
    .load_words (load_words)
  );

  always #5 clk = ~clk;

  // Single-cycle core stand-in: pc advances by 4 whenever out of reset.
  assign core_instr = mem[core_pc[5:2]];

  always @(posedge clk) begin
    core_pc <= core_rst ? 32'd0 : core_pc + 32'd4;
    if (imem_we) begin
      mem[imem_addr[5:2]] <= imem_wdata;
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sk, input logic ab);
    start     = st;
    skip_load = sk;
    abort     = ab;
    @(negedge clk);
    start     = 1'b0;
    skip_load = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] exp_addr);
    logic [31:0] got;
    got = (idx < wr_addr.size()) ? wr_addr[idx] : 32'hDEAD_BEEF;
    checkOutput(tag, got, exp_addr);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_core_rst",    32'(core_rst),    32'd1);
    checkOutput("rst_load_ready",  32'(load_ready),  32'd0);
    checkOutput("rst_imem_we",     32'(imem_we),     32'd0);
    checkOutput("rst_busy",        32'(busy),        32'd0);
    checkOutput("rst_done",        32'(done),        32'd0);
    checkOutput("rst_halt_cause",  32'(halt_cause),  32'd0);
    checkOutput("rst_halt_pc",     halt_pc,          32'd0);
    checkOutput("rst_cycle_count", cycle_count,      32'd0);
    checkOutput("rst_load_words",  32'(load_words),  32'd0);

    // Three-word load with one bubble, program ends in EBREAK
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("load_ready_on", 32'(load_ready), 32'd1);
    checkOutput("load_busy",     32'(busy),       32'd1);
    wr_addr.delete();
    wr_data.delete();
    send_word(NOP, 1'b0);
    send_word(NOP, 1'b0);
    @(negedge clk);
    send_word(INSTR_EBREAK, 1'b1);
    n = 0;
    while (core_rst && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("rst_hold_cycles", 32'(n), 32'd4);
    checkOutput("load3_nwrites", 32'(wr_addr.size()), 32'd3);
    check_write("load3_addr0", 0, 32'h0);
    check_write("load3_addr1", 1, 32'h4);
    check_write("load3_addr2", 2, 32'h8);
    checkOutput("load3_data2", (wr_data.size() > 2) ? wr_data[2] : 32'h0, INSTR_EBREAK);
    checkOutput("load3_words", 32'(load_words), 32'd3);
    wait_done("ebreak_done");
    checkOutput("ebreak_cause", 32'(halt_cause), 32'd1);
    checkOutput("ebreak_pc",    halt_pc,         32'h8);
    checkOutput("ebreak_count", cycle_count,     32'd3);
    checkOutput("ebreak_busy",  32'(busy),       32'd0);
    checkOutput("ebreak_core_rst", 32'(core_rst), 32'd1);

    // All-NOP program runs into the cycle budget
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart_count_clr", cycle_count, 32'd0);
    checkOutput("restart_done_clr",  32'(done),   32'd0);
    send_word(NOP, 1'b0);
    send_word(NOP, 1'b0);
    send_word(NOP, 1'b0);
    send_word(NOP, 1'b1);
    checkOutput("nop_words", 32'(load_words), 32'd4);
    wait_done("timeout_done");
    checkOutput("timeout_cause", 32'(halt_cause), 32'd3);
    checkOutput("timeout_count", cycle_count,     32'd10);
    checkOutput("timeout_pc",    halt_pc,         32'h24);

    // Abort wins over ECALL in the second RUN cycle
    applyStimulus(1'b1, 1'b0, 1'b0);
    send_word(NOP, 1'b0);
    send_word(INSTR_ECALL, 1'b0);
    send_word(NOP, 1'b1);
    n = 0;
    while (core_rst && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("abort_run_entered", 32'(core_rst), 32'd0);
    @(negedge clk);
    checkOutput("abort_instr_is_ecall", core_instr, INSTR_ECALL);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort_done",  32'(done),       32'd1);
    checkOutput("abort_cause", 32'(halt_cause), 32'd0);
    checkOutput("abort_count", cycle_count,     32'd2);
    checkOutput("abort_pc",    halt_pc,         32'h4);

    // Six words, no last: only IMEM_WORDS accepted
    applyStimulus(1'b1, 1'b0, 1'b0);
    wr_addr.delete();
    wr_data.delete();
    load_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load_data = 32'hA000_0000 + 32'(i);
      @(negedge clk);
    end
    load_valid = 1'b0;
    checkOutput("ovf_nwrites", 32'(wr_addr.size()), 32'd4);
    check_write("ovf_addr0", 0, 32'h0);
    check_write("ovf_addr1", 1, 32'h4);
    check_write("ovf_addr2", 2, 32'h8);
    check_write("ovf_addr3", 3, 32'hC);
    checkOutput("ovf_words",      32'(load_words), 32'd4);
    checkOutput("ovf_ready_low",  32'(load_ready), 32'd0);
    checkOutput("ovf_hold_busy",  32'(busy),       32'd1);
    checkOutput("ovf_hold_rst",   32'(core_rst),   32'd1);
    wait_done("ovf_done");
    checkOutput("ovf_cause", 32'(halt_cause), 32'd3);

    // rst in the middle of a load, then reuse the image
    applyStimulus(1'b1, 1'b0, 1'b0);
    send_word(32'h0000_0011, 1'b0);
    send_word(32'h0000_0022, 1'b0);
    checkOutput("midload_words", 32'(load_words), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_words", 32'(load_words), 32'd0);
    checkOutput("midrst_busy",  32'(busy),       32'd0);
    wr_addr.delete();
    wr_data.delete();
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("skip_busy",  32'(busy),       32'd1);
    checkOutput("skip_ready", 32'(load_ready), 32'd0);
    checkOutput("skip_core_rst", 32'(core_rst), 32'd1);
    n = 0;
    while (core_rst && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("skip_hold_cycles", 32'(n), 32'd4);
    checkOutput("skip_nwrites", 32'(wr_addr.size()), 32'd0);
    checkOutput("skip_words",   32'(load_words),     32'd0);

    // Abort in RUN at pc 8, then abort during a new load
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("runabort_pc",    halt_pc,     32'h8);
    checkOutput("runabort_count", cycle_count, 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    wr_addr.delete();
    wr_data.delete();
    send_word(32'h0000_0033, 1'b0);
    load_valid = 1'b1;
    load_data  = 32'h0000_0044;
    abort      = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    checkOutput("ldabort_nwrites", 32'(wr_addr.size()), 32'd1);
    checkOutput("ldabort_done",    32'(done),       32'd1);
    checkOutput("ldabort_cause",   32'(halt_cause), 32'd0);
    checkOutput("ldabort_pc",      halt_pc,         32'h0);
    checkOutput("ldabort_ready",   32'(load_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
